// File: rtl/multi_cycle_control_unit_if.sv
// Control/status bundle between the multi-cycle control FSM and the RV32I datapath.
// The control unit is the master; the datapath (or a bench standing in for it) is the slave.
interface multi_cycle_control_unit_if;
    logic [31:0] inst;
    logic        mem_ready;
    logic        bcond;
    logic        ecall_halt;
    logic        mem_read;
    logic        mem_write;
    logic        i_or_d;
    logic        ir_write;
    logic        pc_write;
    logic        pc_write_not_cond;
    logic        pc_source;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_ctrl_op;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        is_halted;
    logic        retire;

    modport master (
        input  inst, mem_ready, bcond, ecall_halt,
        output mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_not_cond,
               pc_source, alu_src_a, alu_src_b, alu_ctrl_op, reg_write, wb_sel,
               is_halted, retire
    );

    modport slave (
        output inst, mem_ready, bcond, ecall_halt,
        input  mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_not_cond,
               pc_source, alu_src_a, alu_src_b, alu_ctrl_op, reg_write, wb_sel,
               is_halted, retire
    );
endinterface

// File: rtl/multi_cycle_control_unit.sv
// Main control FSM of the multi-cycle RV32I core: FETCH/DECODE/EXEC/MEM/WB/PC_INC/HALT.
// State is registered; every control output is decoded from state, opcode and bcond.
module multi_cycle_control_unit (
    input  logic                          clk,
    input  logic                          reset_n,
    multi_cycle_control_unit_if.master    ctrl
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        PC_INC = 3'd5,
        HALT   = 3'd6
    } state_t;

    state_t     state;
    logic [6:0] opcode;
    logic       known_op;
    logic       unused_inst_bits;

    assign opcode           = ctrl.inst[6:0];
    assign unused_inst_bits = ^ctrl.inst[31:7];
    assign known_op         = opcode inside {OP_R, OP_I, OP_LOAD, OP_STORE,
                                             OP_BRANCH, OP_JAL, OP_JALR};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH: begin
                    if (ctrl.mem_ready) state <= DECODE;
                end
                DECODE: begin
                    // Only the opcode is examined, so every SYSTEM encoding acts as ECALL.
                    if (opcode == OP_SYSTEM) state <= ctrl.ecall_halt ? HALT : PC_INC;
                    else if (known_op)       state <= EXEC;
                    else                     state <= PC_INC;
                end
                EXEC: begin
                    case (opcode)
                        OP_R, OP_I:         state <= WB;
                        OP_LOAD, OP_STORE:  state <= MEM;
                        OP_BRANCH:          state <= ctrl.bcond ? FETCH : PC_INC;
                        OP_JAL, OP_JALR:    state <= FETCH;
                        default:            state <= PC_INC;
                    endcase
                end
                MEM: begin
                    if (ctrl.mem_ready) state <= (opcode == OP_LOAD) ? WB : PC_INC;
                end
                WB:      state <= PC_INC;
                PC_INC:  state <= FETCH;
                HALT:    state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

    // Outputs are gated by reset_n so strobes drop the moment reset asserts.
    always_comb begin
        ctrl.mem_read          = 1'b0;
        ctrl.mem_write         = 1'b0;
        ctrl.i_or_d            = 1'b0;
        ctrl.ir_write          = 1'b0;
        ctrl.pc_write          = 1'b0;
        ctrl.pc_write_not_cond = 1'b0;
        ctrl.pc_source         = 1'b0;
        ctrl.alu_src_a         = 1'b0;
        ctrl.alu_src_b         = 2'b00;
        ctrl.alu_ctrl_op       = 2'b00;
        ctrl.reg_write         = 1'b0;
        ctrl.wb_sel            = 2'b00;
        ctrl.is_halted         = 1'b0;
        ctrl.retire            = 1'b0;
        if (reset_n) begin
            case (state)
                FETCH: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.ir_write = ctrl.mem_ready;
                end
                DECODE: begin
                    ctrl.alu_src_b = 2'b10;
                end
                EXEC: begin
                    case (opcode)
                        OP_R: begin
                            ctrl.alu_src_a   = 1'b1;
                            ctrl.alu_ctrl_op = 2'b10;
                        end
                        OP_I: begin
                            ctrl.alu_src_a   = 1'b1;
                            ctrl.alu_src_b   = 2'b10;
                            ctrl.alu_ctrl_op = 2'b10;
                        end
                        OP_LOAD, OP_STORE: begin
                            ctrl.alu_src_a = 1'b1;
                            ctrl.alu_src_b = 2'b10;
                        end
                        OP_BRANCH: begin
                            ctrl.alu_src_a         = 1'b1;
                            ctrl.alu_ctrl_op       = 2'b01;
                            ctrl.pc_write_not_cond = 1'b1;
                            ctrl.pc_source         = 1'b1;
                            ctrl.retire            = ctrl.bcond;
                        end
                        OP_JAL: begin
                            // Target PC+imm was left in ALUOut by DECODE.
                            ctrl.pc_write  = 1'b1;
                            ctrl.pc_source = 1'b1;
                            ctrl.reg_write = 1'b1;
                            ctrl.wb_sel    = 2'b10;
                            ctrl.retire    = 1'b1;
                        end
                        OP_JALR: begin
                            ctrl.alu_src_a = 1'b1;
                            ctrl.alu_src_b = 2'b10;
                            ctrl.pc_write  = 1'b1;
                            ctrl.reg_write = 1'b1;
                            ctrl.wb_sel    = 2'b10;
                            ctrl.retire    = 1'b1;
                        end
                        default: ;
                    endcase
                end
                MEM: begin
                    ctrl.i_or_d    = 1'b1;
                    ctrl.mem_read  = (opcode == OP_LOAD);
                    ctrl.mem_write = (opcode == OP_STORE);
                end
                WB: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.wb_sel    = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
                end
                PC_INC: begin
                    ctrl.alu_src_b = 2'b01;
                    ctrl.pc_write  = 1'b1;
                    ctrl.retire    = 1'b1;
                end
                HALT: begin
                    ctrl.is_halted = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Bench for multi_cycle_control_unit: per-instruction expected control traces built from
// the instruction-class rules, with randomized classes, stalls and don't-care inputs.
module tb_multi_cycle_control_unit;
    logic clk = 1'b0;
    logic reset_n;

    multi_cycle_control_unit_if bus();

    multi_cycle_control_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ctrl    (bus)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4,
                   C_JAL = 5, C_JALR = 6, C_ECALL = 7, C_UNK = 8;

    typedef struct packed {
        logic [16:0] ctl;
        logic        rdy;
        logic        bc;
        logic        eh;
    } step_t;

    step_t q[$];
    int    checks = 0;
    int    errors = 0;
    int    retire_seen = 0;
    int    retire_exp = 0;
    int    ret_cycle;

    // Observed control word: {mr,mw,iod,irw,pw,pwnc,ps,asa,asb,aop,rw,wb,halted,retire}
    wire [16:0] obs = {bus.mem_read, bus.mem_write, bus.i_or_d, bus.ir_write,
                       bus.pc_write, bus.pc_write_not_cond, bus.pc_source, bus.alu_src_a,
                       bus.alu_src_b, bus.alu_ctrl_op, bus.reg_write, bus.wb_sel,
                       bus.is_halted, bus.retire};

    always @(posedge clk) if (bus.retire === 1'b1) retire_seen++;

    function automatic logic [16:0] cw(input logic mr, mw, iod, irw, pw, pwnc, ps, asa,
                                       input logic [1:0] asb, aop,
                                       input logic rw, input logic [1:0] wb,
                                       input logic h, ret);
        return {mr, mw, iod, irw, pw, pwnc, ps, asa, asb, aop, rw, wb, h, ret};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(1));
    endfunction

    task automatic push(input logic [16:0] c, input logic rdy, input logic bc, input logic eh);
        step_t s;
        s.ctl = c; s.rdy = rdy; s.bc = bc; s.eh = eh;
        q.push_back(s);
    endtask

    task automatic push_pc_inc();
        push(cw(0,0,0,0, 1,0,0,0, 2'b01,2'b00, 0,2'b00, 0,1), rb(), rb(), rb());
    endtask

    // Expected per-cycle control words for one instruction.
    task automatic build(input int cls, input logic bc, input logic eh, input int fs, input int ms);
        q.delete();
        for (int k = 0; k < fs; k++)
            push(cw(1,0,0,0, 0,0,0,0, 2'b00,2'b00, 0,2'b00, 0,0), 1'b0, rb(), rb());
        push(cw(1,0,0,1, 0,0,0,0, 2'b00,2'b00, 0,2'b00, 0,0), 1'b1, rb(), rb());
        push(cw(0,0,0,0, 0,0,0,0, 2'b10,2'b00, 0,2'b00, 0,0), rb(), rb(), eh);
        case (cls)
            C_R: begin
                push(cw(0,0,0,0, 0,0,0,1, 2'b00,2'b10, 0,2'b00, 0,0), rb(), rb(), rb());
                push(cw(0,0,0,0, 0,0,0,0, 2'b00,2'b00, 1,2'b00, 0,0), rb(), rb(), rb());
                push_pc_inc();
            end
            C_I: begin
                push(cw(0,0,0,0, 0,0,0,1, 2'b10,2'b10, 0,2'b00, 0,0), rb(), rb(), rb());
                push(cw(0,0,0,0, 0,0,0,0, 2'b00,2'b00, 1,2'b00, 0,0), rb(), rb(), rb());
                push_pc_inc();
            end
            C_LD, C_ST: begin
                push(cw(0,0,0,0, 0,0,0,1, 2'b10,2'b00, 0,2'b00, 0,0), rb(), rb(), rb());
                for (int k = 0; k <= ms; k++)
                    push(cw(cls == C_LD, cls == C_ST, 1,0, 0,0,0,0, 2'b00,2'b00, 0,2'b00, 0,0),
                         (k == ms), rb(), rb());
                if (cls == C_LD)
                    push(cw(0,0,0,0, 0,0,0,0, 2'b00,2'b00, 1,2'b01, 0,0), rb(), rb(), rb());
                push_pc_inc();
            end
            C_BR: begin
                push(cw(0,0,0,0, 0,1,1,1, 2'b00,2'b01, 0,2'b00, 0,bc), rb(), bc, rb());
                if (!bc) push_pc_inc();
            end
            C_JAL:  push(cw(0,0,0,0, 1,0,1,0, 2'b00,2'b00, 1,2'b10, 0,1), rb(), rb(), rb());
            C_JALR: push(cw(0,0,0,0, 1,0,0,1, 2'b10,2'b00, 1,2'b10, 0,1), rb(), rb(), rb());
            C_ECALL: if (!eh) push_pc_inc();
            default: push_pc_inc();
        endcase
    endtask

    function automatic int cpi(input int cls, input logic bc);
        case (cls)
            C_R, C_I, C_ST: return 5;
            C_LD:           return 6;
            C_BR:           return bc ? 3 : 4;
            default:        return 3;
        endcase
    endfunction

    function automatic logic [31:0] make_inst(input int cls);
        logic [31:0] w;
        logic [6:0]  o;
        w = $urandom;
        case (cls)
            C_R:     o = OP_R;
            C_I:     o = OP_I;
            C_LD:    o = OP_LOAD;
            C_ST:    o = OP_STORE;
            C_BR:    o = OP_BRANCH;
            C_JAL:   o = OP_JAL;
            C_JALR:  o = OP_JALR;
            C_ECALL: o = OP_SYSTEM;
            default: begin
                do o = 7'($urandom);
                while (o inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                                 OP_JAL, OP_JALR, OP_SYSTEM});
            end
        endcase
        w[6:0] = o;
        return w;
    endfunction

    // Drive each step just after the falling edge, check 1 time unit later.
    task automatic run(input int n, input logic [31:0] ins, input string tag);
        bus.inst  = ins;
        ret_cycle = 0;
        for (int i = 0; i < n && i < q.size(); i++) begin
            bus.mem_ready  = q[i].rdy;
            bus.bcond      = q[i].bc;
            bus.ecall_halt = q[i].eh;
            #1;
            checks++;
            assert (obs === q[i].ctl) else begin
                errors++;
                $error("FAIL %s cyc%0d ctl observed=%h expected=%h", tag, i, obs, q[i].ctl);
            end
            if (obs[0] === 1'b1 && ret_cycle == 0) ret_cycle = i + 1;
            @(negedge clk);
        end
    endtask

    task automatic do_instr(input int cls, input logic [31:0] ins, input logic bc,
                            input int fs, input int ms, input string tag);
        int exp_len;
        build(cls, bc, 1'b0, fs, ms);
        run(q.size(), ins, tag);
        retire_exp++;
        exp_len = cpi(cls, bc) + fs + ((cls == C_LD || cls == C_ST) ? ms : 0);
        checks++;
        assert (ret_cycle == exp_len) else begin
            errors++;
            $error("FAIL %s_len retire_cycle observed=%0d expected=%0d", tag, ret_cycle, exp_len);
        end
    endtask

    initial begin
        int cls;
        reset_n        = 1'b0;
        bus.inst       = 32'h0000_0013;
        bus.mem_ready  = 1'b1;
        bus.bcond      = 1'b1;
        bus.ecall_halt = 1'b1;

        @(negedge clk);
        #1;
        checks++;
        assert (obs === 17'h0) else begin
            errors++;
            $error("FAIL reset_outs observed=%h expected=%h", obs, 17'h0);
        end
        @(negedge clk);
        reset_n = 1'b1;

        do_instr(C_R,    32'h0020_8033,    1'b0, 0, 0, "add");
        do_instr(C_LD,   make_inst(C_LD),  1'b0, 0, 2, "lw_stall");
        do_instr(C_BR,   make_inst(C_BR),  1'b1, 0, 0, "beq_taken");
        do_instr(C_BR,   make_inst(C_BR),  1'b0, 0, 0, "beq_not");
        do_instr(C_JAL,  make_inst(C_JAL), 1'b0, 0, 0, "jal");
        do_instr(C_JALR, make_inst(C_JALR),1'b0, 0, 0, "jalr");
        do_instr(C_ST,   make_inst(C_ST),  1'b0, 1, 1, "sw_stall");
        do_instr(C_ECALL,make_inst(C_ECALL),1'b0,0, 0, "ecall_nohalt");

        for (int n = 0; n < 40; n++) begin
            cls = $urandom_range(8, 0);
            do_instr(cls, make_inst(cls), rb(), $urandom_range(2), $urandom_range(2), "rand");
        end

        // Reset asserted while a store is stalled in MEM.
        build(C_ST, 1'b0, 1'b0, 0, 3);
        run(4, make_inst(C_ST), "sw_pre_rst");
        bus.mem_ready = 1'b0;
        #1;
        checks++;
        assert (bus.mem_write === 1'b1) else begin
            errors++;
            $error("FAIL sw_mem_write observed=%b expected=%b", bus.mem_write, 1'b1);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        assert (obs === 17'h0) else begin
            errors++;
            $error("FAIL rst_mid_sw observed=%h expected=%h", obs, 17'h0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        do_instr(C_UNK, 32'h0000_007F, 1'b0, 0, 0, "unk_7f");

        // Halting ECALL then 20 halted cycles.
        build(C_ECALL, 1'b0, 1'b1, 1, 0);
        for (int k = 0; k < 20; k++)
            push(cw(0,0,0,0, 0,0,0,0, 2'b00,2'b00, 0,2'b00, 1,0), rb(), rb(), rb());
        run(q.size(), make_inst(C_ECALL), "ecall_halt");
        #2 reset_n = 1'b0;
        #1;
        checks++;
        assert (bus.is_halted === 1'b0) else begin
            errors++;
            $error("FAIL halt_rst is_halted observed=%b expected=%b", bus.is_halted, 1'b0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        do_instr(C_R, make_inst(C_R), 1'b0, 0, 0, "after_halt");

        checks++;
        assert (retire_seen == retire_exp) else begin
            errors++;
            $error("FAIL retire_count observed=%0d expected=%0d", retire_seen, retire_exp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
